// File: rtl/serial_xnor_comparator.sv
// serial_xnor_comparator: scores two serial bitstreams pairwise with XNOR
// over a fixed-length frame. At frame end it reports the match count, an
// all-match flag and the index of the first mismatching bit.
module serial_xnor_comparator #(
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic             all_match,
   output logic             mismatch_seen,
   output logic [CNT_W-1:0] first_mm_idx
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);

   // Per-frame verdict, captured as one unit at the last accepted bit
   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             all;
      logic             mm;
      logic [CNT_W-1:0] idx;
   } result_t;

   logic [1:0]       state;
   logic [CNT_W-1:0] bit_idx;
   logic [CNT_W-1:0] mcnt;
   logic             mm_flag;
   logic [CNT_W-1:0] mm_idx;

   logic             eq;
   logic             acc;
   logic             last;
   result_t          res_nxt;
   result_t          res_q;

   assign eq   = ~(a ^ b);
   assign acc  = (state == S_RUN) && in_valid;
   assign last = (bit_idx == LAST_IDX);

   // Fold the current bit into the running tally; the first mismatch index
   // is sticky once captured
   always_comb begin
      res_nxt.cnt = mcnt + CNT_W'(eq);
      res_nxt.all = (res_nxt.cnt == FULL_CNT);
      res_nxt.mm  = mm_flag | ~eq;
      res_nxt.idx = (!mm_flag && !eq) ? bit_idx : mm_idx;
   end

   // Frame FSM and internal tally; DONE lasts one cycle and may chain
   // straight into the next frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         bit_idx <= '0;
         mcnt    <= '0;
         mm_flag <= 1'b0;
         mm_idx  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_RUN;
                  bit_idx <= '0;
                  mcnt    <= '0;
                  mm_flag <= 1'b0;
                  mm_idx  <= '0;
               end
            end
            S_RUN: begin
               if (in_valid) begin
                  mcnt    <= res_nxt.cnt;
                  mm_flag <= res_nxt.mm;
                  mm_idx  <= res_nxt.idx;
                  if (last) begin
                     state   <= S_DONE;
                     bit_idx <= '0;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            S_DONE: begin
               // Results already live in the output registers
               bit_idx <= '0;
               mcnt    <= '0;
               mm_flag <= 1'b0;
               mm_idx  <= '0;
               state   <= start ? S_RUN : S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output result registers load on the last bit so they are valid in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else if (acc && last) begin
         res_q <= res_nxt;
      end
   end

   assign busy          = (state == S_RUN);
   assign done          = (state == S_DONE);
   assign match_cnt     = res_q.cnt;
   assign all_match     = res_q.all;
   assign mismatch_seen = res_q.mm;
   assign first_mm_idx  = res_q.idx;

endmodule

// File: tb/tb_serial_xnor_comparator.sv
// Bench for serial_xnor_comparator: table of directed frames plus
// hand-written reset and back-to-back sequences.
module tb_serial_xnor_comparator;

   localparam int FL    = 8;
   localparam int CNT_W = $clog2(FL + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, in_valid, a, b;
   logic             busy, done, all_match, mismatch_seen;
   logic [CNT_W-1:0] match_cnt, first_mm_idx;

   int nvec  = 0;
   int nfail = 0;

   typedef struct {
      string    name;
      bit [7:0] av;        // leftmost bit is sent first (bit index 0)
      bit [7:0] bv;
      int       stall_at;  // accepted-bit index after which in_valid drops, -1 none
      int       stall_len;
      bit       mid_start; // pulse start during the frame (must be ignored)
      bit       b2b;       // hold start high in the DONE cycle
      int       e_cnt;
      bit       e_all;
      bit       e_mm;
      int       e_idx;
   } vec_t;

   vec_t vt[6];

   serial_xnor_comparator #(.FRAME_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .a(a), .b(b), .busy(busy), .done(done), .match_cnt(match_cnt),
      .all_match(all_match), .mismatch_seen(mismatch_seen),
      .first_mm_idx(first_mm_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_zero(input string nm);
      check({nm, " busy"}, int'(busy), 0);
      check({nm, " done"}, int'(done), 0);
      check({nm, " match_cnt"}, int'(match_cnt), 0);
      check({nm, " all_match"}, int'(all_match), 0);
      check({nm, " mismatch_seen"}, int'(mismatch_seen), 0);
      check({nm, " first_mm_idx"}, int'(first_mm_idx), 0);
   endtask

   task automatic check_res(input vec_t v, input string tag);
      check({v.name, tag, " match_cnt"}, int'(match_cnt), v.e_cnt);
      check({v.name, tag, " all_match"}, int'(all_match), int'(v.e_all));
      check({v.name, tag, " mismatch_seen"}, int'(mismatch_seen), int'(v.e_mm));
      check({v.name, tag, " first_mm_idx"}, int'(first_mm_idx), v.e_idx);
   endtask

   // Runs one frame; all driving and sampling happens on the falling edge
   task automatic do_frame(input vec_t v, input bit do_start);
      if (do_start) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      check({v.name, " busy at start"}, int'(busy), 1);
      for (int i = 0; i < FL; i++) begin
         in_valid = 1'b1;
         a        = v.av[7-i];
         b        = v.bv[7-i];
         start    = v.mid_start && (i == 3);
         @(negedge clk);
         start = 1'b0;
         if (i < FL - 1)
            check({v.name, " no early done"}, int'(done), 0);
         if (i == v.stall_at) begin
            for (int s = 0; s < v.stall_len; s++) begin
               in_valid = 1'b0;
               a        = ~a;
               @(negedge clk);
               check({v.name, " stall busy"}, int'(busy), 1);
               check({v.name, " stall done"}, int'(done), 0);
            end
         end
      end
      in_valid = 1'b0;
      check({v.name, " done pulse"}, int'(done), 1);
      check({v.name, " busy in done"}, int'(busy), 0);
      check_res(v, "");
      start = v.b2b;
      @(negedge clk);
      start = 1'b0;
      check({v.name, " done one cycle"}, int'(done), 0);
      check({v.name, " busy after done"}, int'(busy), int'(v.b2b));
      check_res(v, " hold");
   endtask

   initial begin
      vt[0] = '{"ident",   8'b10110010, 8'b10110010, -1, 0, 0, 0, 8, 1, 0, 0};
      vt[1] = '{"stall",   8'b11110000, 8'b11010001,  3, 2, 0, 0, 6, 0, 1, 2};
      vt[2] = '{"invert",  8'b00000000, 8'b11111111, -1, 0, 0, 0, 0, 0, 1, 0};
      vt[3] = '{"b2b_f1",  8'b01010101, 8'b01010101, -1, 0, 1, 1, 8, 1, 0, 0};
      vt[4] = '{"b2b_f2",  8'b11001100, 8'b11001101, -1, 0, 0, 0, 7, 0, 1, 7};
      vt[5] = '{"post_rst",8'b00001111, 8'b10001111, -1, 0, 0, 0, 7, 0, 1, 0};

      // Reset held while inputs toggle
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = i[0]; in_valid = 1'b1; a = i[1]; b = i[0];
         if (i == 3) check_zero("reset");
      end
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("post release idle");

      // Table frames; a frame that follows a back-to-back DONE is already running
      for (int k = 0; k < 5; k++)
         do_frame(vt[k], (k == 0) || !vt[k-1].b2b);

      // Reset mid-frame after 4 accepted bits
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a = 1'b1; b = 1'b1;
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check_zero("mid-frame reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("no done after abort", int'(done), 0);
      end
      in_valid = 1'b0;
      check_zero("after abort idle");

      do_frame(vt[5], 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/serial_xnor_comparator.md
# serial_xnor_comparator

Downstream consumer of per-bit XNOR equality. Compares two serial bitstreams `a` and `b` over a fixed-length frame of `FRAME_LEN` bits. Each accepted bit pair is scored with XNOR (1 = equal). At frame end the block reports the match count, an all-match flag and the index of the first mismatching bit. It sits after the XNOR equality stage in the bit-compare datapath and turns per-bit equality into a per-frame verdict.

## Interface
- `FRAME_LEN`, 8, bits per frame; legal range 2..255.
- `CNT_W`, `$clog2(FRAME_LEN+1)`, width of the count and index fields.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a new frame; sampled in IDLE or DONE only.
- `in_valid` in 1: `a`/`b` carry a valid bit pair this cycle; sampled in RUN only.
- `a` in 1: stream A bit.
- `b` in 1: stream B bit.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse; frame results are valid.
- `match_cnt` out CNT_W: number of equal bit pairs in the last frame.
- `all_match` out 1: high when `match_cnt == FRAME_LEN`.
- `mismatch_seen` out 1: at least one unequal pair in the frame.
- `first_mm_idx` out CNT_W: bit index (0-based) of the first mismatch; 0 when `mismatch_seen` = 0.

## Operation
- Per-bit equality: `eq = ~(a ^ b)`, evaluated only on accepted bits (`in_valid` high in RUN).
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start`.
  - On entry: `bit_idx`, the internal match counter, the internal mismatch flag and the internal first-mismatch index clear to 0.
- RUN, on each accepted bit:
  - `bit_idx` increments.
  - The match counter increments if `eq` = 1.
  - On the first `eq` = 0: the mismatch flag sets and the first-mismatch index captures the current `bit_idx`. Later mismatches do not overwrite it.
- RUN → DONE when the accepted bit has `bit_idx == FRAME_LEN-1`.
- DONE lasts exactly one cycle:
  - `done` = 1.
  - Internal results copy to the output registers `match_cnt`, `all_match`, `mismatch_seen`, `first_mm_idx`.
  - Next state is RUN if `start` = 1 (back-to-back frames, counters cleared as above), otherwise IDLE.
- Output result registers hold their value until the next DONE. They are not cleared by `start`.
- Ignored inputs:
  - `start` while in RUN: no restart.
  - `in_valid`/`a`/`b` in IDLE or DONE.
  - `in_valid` low in RUN: stall; no state change.
- Counter width: the match counter saturates by construction at FRAME_LEN, so it never wraps. `bit_idx` never exceeds FRAME_LEN-1.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state = IDLE.
  - `busy` = 0, `done` = 0, `match_cnt` = 0, `all_match` = 0, `mismatch_seen` = 0, `first_mm_idx` = 0.
  - All internal counters = 0.
- Reset mid-frame aborts the frame. No `done` is produced and results revert to 0.
- Operation resumes on the first rising edge after `rst_n` rises, in IDLE.
- `start` sampled at edge t: `busy` = 1 from t+1. The first bit pair can be accepted at edge t+1.
- Last bit accepted at edge k: `done` = 1 and results valid during cycle k+1. `busy` = 0 in cycle k+1.
- Latency from last bit to result is 1 cycle.
- Minimum frame duration is FRAME_LEN cycles of RUN plus 1 cycle of DONE.
- Back-to-back: `start` high during the DONE cycle gives `busy` = 1 in the next cycle with no IDLE gap.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use FRAME_LEN = 8.
- Reset: hold `rst_n` = 0 while toggling inputs → all outputs 0. Release, then `start` → `busy` = 1 on the next cycle.
- Identical streams: `start`, then 8 consecutive valid pairs `a` = `b` = 10110010 → `done` pulse 1 cycle after the 8th bit, `match_cnt` = 8, `all_match` = 1, `mismatch_seen` = 0, `first_mm_idx` = 0.
- Mismatches with stalls: `a` = 11110000, `b` = 11010001, with `in_valid` low for 2 cycles after bit 3 → `match_cnt` = 6, `all_match` = 0, `mismatch_seen` = 1, `first_mm_idx` = 2. `done` appears 1 cycle after the 8th accepted bit.
- Fully inverted: `a` = 00000000, `b` = 11111111 → `match_cnt` = 0, `first_mm_idx` = 0, `mismatch_seen` = 1.
- Back-to-back frames with ignored `start`: frame 1 all equal; `start` pulsed mid-frame (no effect); `start` high in the DONE cycle; frame 2 has a mismatch at bit 7 → frame 1 gives `match_cnt` = 8. Frame 2 starts with no IDLE cycle and gives `match_cnt` = 7, `first_mm_idx` = 7. Results from frame 1 hold until frame 2's `done`.
- Reset mid-frame: assert `rst_n` = 0 after 4 bits → immediate return to IDLE, no `done`, outputs 0. A following full frame reports normally.
